inst_rom_arbiter: RTL and testbench
===================================

// Module: inst_rom_arbiter
// PURPOSE
//  Shares the single-port instruction ROM between the IF stage (port I) and a debug/loader read master (port D).
//  Drives ROM ce/addr each cycle and registers the returned word back to the winning requester.
//  Results arrive with 1-cycle latency; IF stalls via stallreq_if while port D owns the ROM.
//  Aging counter prevents D starvation; optional D lock grants short bursts.
// PARAMETERS
//  ADDR_W      32  byte-address width, both ports
//  DATA_W      32  instruction word width
//  STARVE_MAX  8   consecutive cycles D may wait before forced grant (>=1)
//  LOCK_MAX    4   max consecutive D grants under dbg_lock (>=1)
// PORTS
//  clk          in   1       clock, rising edge
//  rst          in   1       async reset, active-high
//  if_req       in   1       IF requests a fetch this cycle
//  if_addr      in   ADDR_W  IF byte address
//  if_gnt       out  1       IF request accepted this cycle (combinational)
//  if_rvalid    out  1       if_rdata valid (1 cycle after if_gnt)
//  if_rdata     out  DATA_W  fetched word for IF
//  stallreq_if  out  1       if_req && !if_gnt (to pipeline ctrl)
//  dbg_req      in   1       D requests a read
//  dbg_addr     in   ADDR_W  D byte address
//  dbg_lock     in   1       D requests back-to-back ownership
//  dbg_gnt      out  1       D request accepted this cycle (combinational)
//  dbg_rvalid   out  1       dbg_rdata valid (1 cycle after dbg_gnt)
//  dbg_rdata    out  DATA_W  fetched word for D
//  dbg_err      out  1       with dbg_rvalid: dbg_addr[1:0]!=0 at grant
//  rom_ce       out  1       ROM chip enable (1=enable)
//  rom_addr     out  ADDR_W  ROM byte address
//  rom_inst     in   DATA_W  ROM read data (combinational from rom_ce/rom_addr)
// BEHAVIOUR
//  Reset: all outputs 0; rdata regs 0; wait_cnt=0; lock_cnt=0; state=ARB.
//  States: ARB (IF priority) and DLOCK (D owns).
//  ARB grant: D wins iff dbg_req && (!if_req || wait_cnt==STARVE_MAX); else IF wins if if_req.
//    At most one gnt per cycle. No requests -> rom_ce=0, rom_addr=0.
//  wait_cnt: increments (saturates at STARVE_MAX) each cycle dbg_req && !dbg_gnt; clears on dbg_gnt or !dbg_req.
//  ARB->DLOCK when D granted && dbg_lock; lock_cnt<=1.
//  DLOCK: D always wins when dbg_req (IF stalled); lock_cnt++ per D grant.
//    ->ARB when !dbg_lock, !dbg_req, or lock_cnt==LOCK_MAX; final D grant completes normally.
//    Leaving on LOCK_MAX: next cycle IF has priority and wait_cnt restarts from 0.
//  ROM drive: granted port -> rom_ce=1, rom_addr={addr[ADDR_W-1:2],2'b00}; word-aligned, low bits ignored.
//  Read pipeline: at clock edge after grant, winner's rdata<=rom_inst, rvalid<=1.
//    Non-winner rvalid<=0, rdata holds. rvalid is a 1-cycle pulse per grant.
//  dbg_err registered alongside dbg_rvalid; data still returned. IF misalignment not checked.
//  Requester holds req/addr until gnt; arbiter needs no stability after gnt.
//  stallreq_if combinational; never asserts when if_req=0.
//  Async rst mid-transfer: pending rvalid dropped (0), state->ARB, counters cleared.
// TESTING
//  1. Only if_req, addrs 0x0,0x4,0x8 in cycles 1-3 -> if_gnt each cycle;
//     if_rvalid cycles 2-4, data=mem[0..2]; stallreq_if=0.
//  2. if_req and dbg_req both held, dbg_lock=0, STARVE_MAX=8 -> IF granted 8 cycles;
//     9th cycle dbg_gnt=1, stallreq_if=1; then IF regains.
//  3. IF idle, dbg_req+dbg_lock held, LOCK_MAX=4, if_req raised mid-burst ->
//     4 consecutive dbg_gnt, IF granted on 5th cycle.
//  4. dbg_addr=0x0000000A -> rom_addr=0x08; dbg_rvalid=1 with dbg_err=1, dbg_rdata=mem[2].
//  5. rst asserted async mid-cycle after a grant -> rvalid/gnt/rom_ce drop immediately;
//     after release, first requester granted in ARB.
//  6. No requests for 5 cycles -> rom_ce=0, both rvalid=0, wait_cnt stays 0.

Source files
------------

// File: rtl/inst_rom_arbiter_if.sv
// Bundle of every bus signal between the IF stage, the debug/loader master, the ROM and the arbiter.
// Handshake: a requester raises *_req with a stable *_addr and holds both until the same-cycle *_gnt;
// each grant yields exactly one *_rvalid pulse on the following clock edge, carrying *_rdata.
interface inst_rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stallreq_if;
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_err;
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;
  logic              arb_state;  // 0 = ARB, 1 = DLOCK

  modport slave (
    input  if_req, if_addr, dbg_req, dbg_addr, dbg_lock, rom_inst,
    output if_gnt, if_rvalid, if_rdata, stallreq_if,
           dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
           rom_ce, rom_addr, arb_state
  );

  modport master (
    output if_req, if_addr, dbg_req, dbg_addr, dbg_lock, rom_inst,
    input  if_gnt, if_rvalid, if_rdata, stallreq_if,
           dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
           rom_ce, rom_addr, arb_state
  );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Arbitrates the single-port instruction ROM between the IF stage and a debug/loader master,
// with IF priority, an aging counter against debug starvation and bounded debug lock bursts.
module inst_rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 8,
  parameter int LOCK_MAX   = 4
) (
  input logic               clk,
  input logic               rst,
  inst_rom_arbiter_if.slave bus
);
  localparam int WC_W = $clog2(STARVE_MAX + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);
  // A burst of one grant is just a normal grant, so DLOCK is only entered when LOCK_MAX allows more.
  localparam bit LOCK_EN = (LOCK_MAX > 1);

  typedef enum logic {ARB = 1'b0, DLOCK = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              dbg_err_q, dbg_err_d;
  logic              if_gnt, dbg_gnt;
  logic              unused_if_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      lock_cnt_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      dbg_rvalid_q <= 1'b0;
      dbg_rdata_q  <= '0;
      dbg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      dbg_rdata_q  <= dbg_rdata_d;
      dbg_err_q    <= dbg_err_d;
    end
  end

  // Grants are suppressed while rst is high so the ROM and requesters see an idle bus at once.
  always_comb begin
    dbg_gnt = 1'b0;
    if_gnt  = 1'b0;
    if (!rst) begin
      if (state_q == DLOCK) dbg_gnt = bus.dbg_req;
      else dbg_gnt = bus.dbg_req && (!bus.if_req || wait_cnt_q == WC_W'(STARVE_MAX));
      if_gnt = bus.if_req && !dbg_gnt;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (dbg_gnt && bus.dbg_lock && LOCK_EN) begin
          state_d    = DLOCK;
          lock_cnt_d = LC_W'(1);
        end
      end
      DLOCK: begin
        if (dbg_gnt) lock_cnt_d = lock_cnt_q + LC_W'(1);
        if (!dbg_gnt || !bus.dbg_lock || lock_cnt_d == LC_W'(LOCK_MAX)) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    endcase

    wait_cnt_d = '0;
    if (bus.dbg_req && !dbg_gnt)
      wait_cnt_d = (wait_cnt_q == WC_W'(STARVE_MAX)) ? wait_cnt_q : wait_cnt_q + WC_W'(1);

    if_rvalid_d  = if_gnt;
    if_rdata_d   = if_gnt ? bus.rom_inst : if_rdata_q;
    dbg_rvalid_d = dbg_gnt;
    dbg_rdata_d  = dbg_gnt ? bus.rom_inst : dbg_rdata_q;
    dbg_err_d    = dbg_gnt && (bus.dbg_addr[1:0] != 2'b00);
  end

  assign bus.if_gnt      = if_gnt;
  assign bus.dbg_gnt     = dbg_gnt;
  assign bus.stallreq_if = bus.if_req && !if_gnt && !rst;
  assign bus.rom_ce      = if_gnt || dbg_gnt;
  assign bus.rom_addr    = dbg_gnt ? {bus.dbg_addr[ADDR_W-1:2], 2'b00} :
                           if_gnt  ? {bus.if_addr[ADDR_W-1:2], 2'b00}  : '0;
  assign bus.if_rvalid   = if_rvalid_q;
  assign bus.if_rdata    = if_rdata_q;
  assign bus.dbg_rvalid  = dbg_rvalid_q;
  assign bus.dbg_rdata   = dbg_rdata_q;
  assign bus.dbg_err     = dbg_err_q;
  assign bus.arb_state   = state_q;
  // IF fetch alignment is the pipeline's responsibility; its low address bits are dropped.
  assign unused_if_lo    = ^bus.if_addr[1:0];
endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Randomised and directed bench for inst_rom_arbiter: a grant-level reference model predicts
// the winner each cycle and queues the expected read data checked by a separate monitor.
module tb_inst_rom_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SM = 8;
  localparam int LM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inst_rom_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  inst_rom_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM), .LOCK_MAX(LM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] mem [64];
  assign bus.rom_inst = mem[bus.rom_addr[7:2]];

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] if_exp_q[$];
  logic [DW:0]   dbg_exp_q[$];

  // Reference model: how long D has been kept waiting, and how many grants the current lock burst holds.
  int d_waited  = 0;
  int burst_len = 0;

  logic ig, dg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    d_waited  = 0;
    burst_len = 0;
    if_exp_q.delete();
    dbg_exp_q.delete();
  endtask

  task automatic cycle(input logic ir, input logic [AW-1:0] ia, input logic dr,
                       input logic [AW-1:0] da, input logic dl,
                       output logic i_win, output logic d_win);
    logic [AW-1:0] exp_addr;
    @(posedge clk);
    #1;
    bus.if_req   = ir;
    bus.if_addr  = ia;
    bus.dbg_req  = dr;
    bus.dbg_addr = da;
    bus.dbg_lock = dl;
    @(negedge clk);
    d_win = dr && (burst_len > 0 || !ir || d_waited >= SM);
    i_win = ir && !d_win;
    exp_addr = d_win ? (da & ~32'h3) : i_win ? (ia & ~32'h3) : 32'h0;
    chk("arb_state", bus.arb_state, burst_len > 0);
    chk("if_gnt", bus.if_gnt, i_win);
    chk("dbg_gnt", bus.dbg_gnt, d_win);
    chk("stallreq_if", bus.stallreq_if, ir && !i_win);
    chk("rom_ce", bus.rom_ce, i_win || d_win);
    chk("rom_addr", bus.rom_addr, exp_addr);
    if (i_win) if_exp_q.push_back(mem[ia[7:2]]);
    if (d_win) dbg_exp_q.push_back({da[1:0] != 2'b00, mem[da[7:2]]});
    if (d_win) begin
      d_waited = 0;
      if (burst_len > 0) begin
        burst_len++;
        if (!dl || burst_len == LM) burst_len = 0;
      end else if (dl && LM > 1) begin
        burst_len = 1;
      end
    end else begin
      burst_len = 0;
      d_waited  = dr ? ((d_waited < SM) ? d_waited + 1 : SM) : 0;
    end
  endtask

  // Monitor: every grant must be answered by exactly one rvalid pulse on the next edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst) begin
        if (if_exp_q.size() > 0) begin
          chk("if_rvalid", bus.if_rvalid, 1'b1);
          chk("if_rdata", bus.if_rdata, if_exp_q.pop_front());
        end else begin
          chk("if_rvalid_idle", bus.if_rvalid, 1'b0);
        end
        if (dbg_exp_q.size() > 0) begin
          chk("dbg_rvalid", bus.dbg_rvalid, 1'b1);
          chk("dbg_err_rdata", {bus.dbg_err, bus.dbg_rdata}, dbg_exp_q.pop_front());
        end else begin
          chk("dbg_rvalid_idle", bus.dbg_rvalid, 1'b0);
        end
      end
    end
  end

  initial begin
    int cnt;
    logic ir, dr, dl;
    logic [AW-1:0] ia, da;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dbg_req = 1'b0; bus.dbg_addr = '0; bus.dbg_lock = 1'b0;

    #2;
    chk("rst_outputs", {bus.if_gnt, bus.if_rvalid, bus.stallreq_if, bus.dbg_gnt, bus.dbg_rvalid,
                        bus.dbg_err, bus.rom_ce, bus.arb_state}, 8'h00);
    chk("rst_rdata", {bus.if_rdata, bus.dbg_rdata}, 64'h0);
    chk("rst_rom_addr", bus.rom_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fetches from IF alone
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'(4 * k), 1'b0, '0, 1'b0, ig, dg);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, dg);

    // IF and D both requesting: D is aged in after STARVE_MAX IF grants
    cnt = 0;
    dr = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 32'(4 * k), dr, 32'h30, 1'b0, ig, dg);
      if (dr && ig) cnt++;
      if (dg) dr = 1'b0;
    end
    chk("starve_if_grants", cnt, SM);

    // Locked D burst, IF joins mid-burst
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cycle(k >= 2, 32'h40, 1'b1, 32'(8 + 4 * k), 1'b1, ig, dg);
      if (dg && cnt == k) cnt++;
      if (k == 4) chk("burst_end_if_gnt", ig, 1'b1);
    end
    chk("burst_d_grants", cnt, LM);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, dg);

    // Misaligned debug read
    cycle(1'b0, '0, 1'b1, 32'h0000000A, 1'b0, ig, dg);

    // Idle bus
    for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, dg);

    // Async reset mid-cycle with D partly aged and a read in flight
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'(4 * k), 1'b1, 32'h50, 1'b0, ig, dg);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {bus.if_gnt, bus.if_rvalid, bus.dbg_gnt, bus.dbg_rvalid,
                           bus.rom_ce, bus.stallreq_if, bus.arb_state}, 7'h00);
    model_reset();
    bus.if_req = 1'b0; bus.dbg_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    dr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'(4 * k), dr, 32'h50, 1'b0, ig, dg);
      if (dr && ig) cnt++;
      if (dg) dr = 1'b0;
    end
    chk("post_rst_if_grants", cnt, SM);

    // Random traffic; a requester keeps req/addr until granted
    ir = 1'b0; dr = 1'b0; dl = 1'b0; ia = '0; da = '0;
    for (int k = 0; k < 500; k++) begin
      if (!ir || ig) begin
        ir = ($urandom_range(0, 3) != 0);
        ia = 32'($urandom_range(0, 255));
      end
      if (!dr || dg) begin
        dr = ($urandom_range(0, 2) == 0);
        da = 32'($urandom_range(0, 255));
        dl = $urandom_range(0, 1) == 1;
      end
      cycle(ir, ia, dr, da, dl, ig, dg);
    end
    cycle(1'b0, '0, 1'b0, '0, 1'b0, ig, dg);
    @(posedge clk);
    #3;
    chk("drain", if_exp_q.size() + dbg_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
